// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix engine scheduler: field widths, opcodes,
// engine mode, error codes, scheduler state encoding and the latched command
// payload that is handed to the compute engine.
package matrix_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SCAL_W = 4;
  localparam int unsigned DIM_W  = 4;
  localparam int unsigned DATA_W = 200;
  localparam int unsigned MODE_W = 4;
  localparam int unsigned ERR_W  = 3;

  localparam logic [OP_W-1:0] OP_TRANSPOSE = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD       = 3'b001;
  localparam logic [OP_W-1:0] OP_SCALAR    = 3'b010;
  localparam logic [OP_W-1:0] OP_MULTIPLY  = 3'b011;
  localparam logic [OP_W-1:0] OP_CONV      = 3'b100;

  localparam logic [MODE_W-1:0] MODE_IDLE    = 4'b0000;
  localparam logic [MODE_W-1:0] MODE_OP_EXEC = 4'b0110;

  localparam logic [ERR_W-1:0] ERR_NONE        = 3'b000;
  localparam logic [ERR_W-1:0] ERR_OP_MISMATCH = 3'b010;
  localparam logic [ERR_W-1:0] ERR_INVALID_OP  = 3'b011;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT     = 3'b100;

  // S_DRAIN is the post-timeout tail of RESP: engine may still be running.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RESP, S_DRAIN
  } sched_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [SCAL_W-1:0] scalar;
    logic [DIM_W-1:0]  a_m;
    logic [DIM_W-1:0]  a_n;
    logic [DIM_W-1:0]  b_m;
    logic [DIM_W-1:0]  b_n;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              a_valid;
    logic              b_valid;
  } sched_cmd_t;

endpackage

// File: rtl/matrix_op_scheduler_if.sv
// Requester-side bundle of the matrix scheduler: two requesters packed side by
// side ({req1, req0}) plus the one-hot ready and response signals.
// master: command front-ends; slave: the scheduler.
interface matrix_op_scheduler_if;
  import matrix_pkg::*;

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*OP_W-1:0]     req_op;
  logic [NREQ*SCAL_W-1:0]   req_scalar;
  logic [NREQ*DIM_W-1:0]    req_a_m;
  logic [NREQ*DIM_W-1:0]    req_a_n;
  logic [NREQ*DIM_W-1:0]    req_b_m;
  logic [NREQ*DIM_W-1:0]    req_b_n;
  logic [NREQ*DATA_W-1:0]   req_a_data;
  logic [NREQ*DATA_W-1:0]   req_b_data;
  logic [NREQ-1:0]          req_a_valid;
  logic [NREQ-1:0]          req_b_valid;
  logic [NREQ-1:0]          rsp_valid;
  logic [ERR_W-1:0]         rsp_error;

  modport master (
    output req_valid, req_op, req_scalar, req_a_m, req_a_n, req_b_m, req_b_n,
           req_a_data, req_b_data, req_a_valid, req_b_valid,
    input  req_ready, rsp_valid, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_scalar, req_a_m, req_a_n, req_b_m, req_b_n,
           req_a_data, req_b_data, req_a_valid, req_b_valid,
    output req_ready, rsp_valid, rsp_error
  );

endinterface

// File: rtl/sched_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst (sync, active-high); req_i[1:0] requests; update_i commits
// the current grant; grant_c_o[1:0] combinational one-hot grant.
// The pointer resets to 1 so requester 0 wins the first contention.
module sched_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_c_o
);

  logic last_grant_q;

  // Single requester wins outright; on contention the one not served last wins.
  always_comb begin
    grant_c_o = 2'b00;
    case (req_i)
      2'b01:   grant_c_o = 2'b01;
      2'b10:   grant_c_o = 2'b10;
      2'b11:   grant_c_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_c_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (update_i) begin
      last_grant_q <= grant_c_o[1];
    end
  end

endmodule

// File: rtl/matrix_op_scheduler.sv
// Shares the matrix compute engine between the console (req 0) and the
// auto-demo/self-test generator (req 1): arbitrates, latches the winner's
// command, sequences mode/start toward the engine, waits for done with a
// timeout guard and returns a one-hot response to the winner.
// Ports: clk, rst (sync, active-high); req_if (slave side of the requester
// bundle); busy; eng_* command outputs; eng_done/eng_error from the engine.
// Optional MATRIX_SCHED_STATS_EN adds stat_ops/stat_errs/stat_timeouts.
module matrix_op_scheduler
  import matrix_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_op_scheduler_if.slave req_if,
  output logic                 busy,
  output logic [MODE_W-1:0]    eng_mode,
  output logic [OP_W-1:0]      eng_op,
  output logic [SCAL_W-1:0]    eng_scalar,
  output logic                 eng_start,
  output logic [DIM_W-1:0]     eng_a_m,
  output logic [DIM_W-1:0]     eng_a_n,
  output logic [DIM_W-1:0]     eng_b_m,
  output logic [DIM_W-1:0]     eng_b_n,
  output logic [DATA_W-1:0]    eng_a_data,
  output logic [DATA_W-1:0]    eng_b_data,
  output logic                 eng_a_valid,
  output logic                 eng_b_valid,
  input  logic                 eng_done,
  input  logic [ERR_W-1:0]     eng_error
`ifdef MATRIX_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_errs,
  output logic [7:0]           stat_timeouts
`endif
);

  // Wide enough for the drain window of 2*TIMEOUT_CYCLES at the maximum.
  localparam int unsigned CNT_W = 17;

  sched_state_e         state_q;
  sched_cmd_t           cmd_q;
  sched_cmd_t           req_cmd [NREQ];
  logic                 gnt_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 timed_out_q;
  logic                 eng_start_q;
  logic [MODE_W-1:0]    eng_mode_q;
  logic                 busy_q;
  logic [NREQ-1:0]      rsp_valid_q;
  logic [ERR_W-1:0]     rsp_error_q;
  logic [NREQ-1:0]      grant_c;
  logic                 accept_c;
  logic                 timeout_hit_c;
  logic                 drain_end_c;

  // Unpack each requester's slice of the shared bundle into a command.
  for (genvar i = 0; i < NREQ; i++) begin : g_cmd
    assign req_cmd[i] = '{
      op:      req_if.req_op[i*OP_W +: OP_W],
      scalar:  req_if.req_scalar[i*SCAL_W +: SCAL_W],
      a_m:     req_if.req_a_m[i*DIM_W +: DIM_W],
      a_n:     req_if.req_a_n[i*DIM_W +: DIM_W],
      b_m:     req_if.req_b_m[i*DIM_W +: DIM_W],
      b_n:     req_if.req_b_n[i*DIM_W +: DIM_W],
      a_data:  req_if.req_a_data[i*DATA_W +: DATA_W],
      b_data:  req_if.req_b_data[i*DATA_W +: DATA_W],
      a_valid: req_if.req_a_valid[i],
      b_valid: req_if.req_b_valid[i]
    };
  end

  sched_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_if.req_valid),
    .update_i  (accept_c),
    .grant_c_o (grant_c)
  );

  // The accept strobe is the grant itself during the IDLE cycle.
  assign accept_c      = !rst && (state_q == S_IDLE) && (|grant_c);
  assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign drain_end_c   = eng_done || (cnt_q == CNT_W'(2 * TIMEOUT_CYCLES - 1));

  // Scheduler FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_mode_q  <= MODE_IDLE;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_error_q <= ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            cmd_q      <= req_cmd[grant_c[1]];
            gnt_q      <= grant_c[1];
            eng_mode_q <= MODE_OP_EXEC;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          eng_start_q <= 1'b1;
          state_q     <= S_START;
        end
        S_START: begin
          eng_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // done has priority over a coincident timeout
          if (eng_done) begin
            rsp_error_q <= eng_error;
            rsp_valid_q <= {gnt_q, !gnt_q};
            timed_out_q <= 1'b0;
            state_q     <= S_RESP;
          end else if (timeout_hit_c) begin
            rsp_error_q <= ERR_TIMEOUT;
            rsp_valid_q <= {gnt_q, !gnt_q};
            timed_out_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_q <= '0;
          rsp_error_q <= ERR_NONE;
          cnt_q       <= cnt_q + CNT_W'(1);
          if (timed_out_q && !eng_done) begin
            state_q <= S_DRAIN;
          end else begin
            timed_out_q <= 1'b0;
            eng_mode_q  <= MODE_IDLE;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (drain_end_c) begin
            timed_out_q <= 1'b0;
            eng_mode_q  <= MODE_IDLE;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_if.req_ready = accept_c ? grant_c : 2'b00;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_error = rsp_error_q;

  assign busy        = busy_q;
  assign eng_mode    = eng_mode_q;
  assign eng_start   = eng_start_q;
  assign eng_op      = cmd_q.op;
  assign eng_scalar  = cmd_q.scalar;
  assign eng_a_m     = cmd_q.a_m;
  assign eng_a_n     = cmd_q.a_n;
  assign eng_b_m     = cmd_q.b_m;
  assign eng_b_n     = cmd_q.b_n;
  assign eng_a_data  = cmd_q.a_data;
  assign eng_b_data  = cmd_q.b_data;
  assign eng_a_valid = cmd_q.a_valid;
  assign eng_b_valid = cmd_q.b_valid;

`ifdef MATRIX_SCHED_STATS_EN
  logic             resp_fire_c;
  logic [ERR_W-1:0] resp_err_c;
  logic [15:0]      stat_ops_q;
  logic [15:0]      stat_errs_q;
  logic [7:0]       stat_timeouts_q;

  assign resp_fire_c = (state_q == S_WAIT) && (eng_done || timeout_hit_c);
  assign resp_err_c  = eng_done ? eng_error : ERR_TIMEOUT;

  // Saturating response statistics, counted on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q      <= '0;
      stat_errs_q     <= '0;
      stat_timeouts_q <= '0;
    end else if (resp_fire_c) begin
      if (stat_ops_q != '1) stat_ops_q <= stat_ops_q + 16'd1;
      if ((resp_err_c != ERR_NONE) && (stat_errs_q != '1)) stat_errs_q <= stat_errs_q + 16'd1;
      if (!eng_done && (stat_timeouts_q != '1)) stat_timeouts_q <= stat_timeouts_q + 8'd1;
    end
  end

  assign stat_ops      = stat_ops_q;
  assign stat_errs     = stat_errs_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Directed testbench for matrix_op_scheduler (TIMEOUT_CYCLES = 16).
module tb_matrix_op_scheduler;
  import matrix_pkg::*;

  logic                clk;
  logic                rst;
  logic                busy;
  logic [MODE_W-1:0]   eng_mode;
  logic [OP_W-1:0]     eng_op;
  logic [SCAL_W-1:0]   eng_scalar;
  logic                eng_start;
  logic [DIM_W-1:0]    eng_a_m, eng_a_n, eng_b_m, eng_b_n;
  logic [DATA_W-1:0]   eng_a_data, eng_b_data;
  logic                eng_a_valid, eng_b_valid;
  logic                eng_done;
  logic [ERR_W-1:0]    eng_error;
`ifdef MATRIX_SCHED_STATS_EN
  logic [15:0]         stat_ops, stat_errs;
  logic [7:0]          stat_timeouts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  matrix_op_scheduler_if bus ();

  matrix_op_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (bus),
    .busy        (busy),
    .eng_mode    (eng_mode),
    .eng_op      (eng_op),
    .eng_scalar  (eng_scalar),
    .eng_start   (eng_start),
    .eng_a_m     (eng_a_m),
    .eng_a_n     (eng_a_n),
    .eng_b_m     (eng_b_m),
    .eng_b_n     (eng_b_n),
    .eng_a_data  (eng_a_data),
    .eng_b_data  (eng_b_data),
    .eng_a_valid (eng_a_valid),
    .eng_b_valid (eng_b_valid),
    .eng_done    (eng_done),
    .eng_error   (eng_error)
`ifdef MATRIX_SCHED_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_errs     (stat_errs),
    .stat_timeouts (stat_timeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] sc,
                         input logic [3:0] am, input logic [3:0] an,
                         input logic [3:0] bm, input logic [3:0] bn,
                         input logic [199:0] ad, input logic [199:0] bd);
    bus.req_op[i*3 +: 3]         = op;
    bus.req_scalar[i*4 +: 4]     = sc;
    bus.req_a_m[i*4 +: 4]        = am;
    bus.req_a_n[i*4 +: 4]        = an;
    bus.req_b_m[i*4 +: 4]        = bm;
    bus.req_b_n[i*4 +: 4]        = bn;
    bus.req_a_data[i*200 +: 200] = ad;
    bus.req_b_data[i*200 +: 200] = bd;
    bus.req_a_valid[i]           = 1'b1;
    bus.req_b_valid[i]           = 1'b1;
    bus.req_valid[i]             = 1'b1;
  endtask

  // One full transaction starting in an IDLE cycle; the engine answers after
  // wait_cyc WAIT cycles with error code err.
  task automatic run_txn(input string tag, input logic [1:0] g, input int wait_cyc,
                         input logic [2:0] err, input logic [2:0] exp_op,
                         input logic [199:0] exp_a);
    int gi = g[1] ? 1 : 0;
    #1;
    chk({tag, ".ready"}, bus.req_ready, g);
    tick();  // LOAD
    bus.req_valid[gi]            = 1'b0;
    bus.req_op[gi*3 +: 3]        = 3'b111;
    bus.req_a_data[gi*200 +: 200] = '1;
    chk({tag, ".load_busy"}, busy, 1);
    chk({tag, ".load_mode"}, eng_mode, MODE_OP_EXEC);
    chk({tag, ".load_start"}, eng_start, 0);
    chk({tag, ".load_op"}, eng_op, exp_op);
    chk({tag, ".load_adata"}, eng_a_data, exp_a);
    tick();  // START
    chk({tag, ".start_hi"}, eng_start, 1);
    tick();  // WAIT
    chk({tag, ".start_lo"}, eng_start, 0);
    for (int k = 0; k < wait_cyc; k++) begin
      chk({tag, ".wait_rsp"}, bus.rsp_valid, 0);
      chk({tag, ".wait_rdy"}, bus.req_ready, 0);
      tick();
    end
    eng_done  = 1'b1;
    eng_error = err;
    tick();  // RESP
    eng_done  = 1'b0;
    eng_error = '0;
    chk({tag, ".rsp_valid"}, bus.rsp_valid, g);
    chk({tag, ".rsp_error"}, bus.rsp_error, err);
    chk({tag, ".rsp_mode"}, eng_mode, MODE_OP_EXEC);
    chk({tag, ".rsp_rdy"}, bus.req_ready, 0);
    chk({tag, ".rsp_hold"}, eng_a_data, exp_a);
    tick();  // IDLE
    chk({tag, ".idle_rsp"}, bus.rsp_valid, 0);
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_mode"}, eng_mode, MODE_IDLE);
  endtask

  initial begin
    rst = 1'b1;
    eng_done = 1'b0;
    eng_error = '0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_scalar = '0;
    bus.req_a_m = '0; bus.req_a_n = '0; bus.req_b_m = '0; bus.req_b_n = '0;
    bus.req_a_data = '0; bus.req_b_data = '0;
    bus.req_a_valid = '0; bus.req_b_valid = '0;
    tick();
    tick();
    chk("reset.busy", busy, 0);
    chk("reset.mode", eng_mode, 0);
    chk("reset.start", eng_start, 0);
    chk("reset.rsp_valid", bus.rsp_valid, 0);
    chk("reset.rsp_error", bus.rsp_error, 0);
    chk("reset.ready", bus.req_ready, 0);
    chk("reset.eng_adata", eng_a_data, 0);
    rst = 1'b0;

    // Contention out of reset: req0 (add 2x2) first, then req1 (mismatched multiply)
    set_req(0, OP_ADD, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 200'h04030201, 200'h08070605);
    set_req(1, OP_MULTIPLY, 4'd1, 4'd2, 4'd3, 4'd2, 4'd2, 200'h0A0B0C0D0E0F, 200'h11121314);
    run_txn("t1_add", 2'b01, 5, ERR_NONE, OP_ADD, 200'h04030201);
    chk("t1.eng_scalar_kept", eng_scalar, 4'd3);
    set_req(0, OP_SCALAR, 4'd7, 4'd3, 4'd3, 4'd0, 4'd0, 200'h99887766, 200'h0);
    run_txn("t3_mism", 2'b10, 3, ERR_OP_MISMATCH, OP_MULTIPLY, 200'h0A0B0C0D0E0F);
    chk("t3.eng_b_n", eng_b_n, 4'd2);
    set_req(1, OP_TRANSPOSE, 4'd0, 4'd4, 4'd2, 4'd0, 4'd0, 200'h55AA55AA, 200'h0);
    run_txn("t2_rr", 2'b01, 2, ERR_NONE, OP_SCALAR, 200'h99887766);
    // done coincides with the last timeout cycle: done wins
    run_txn("t6_coinc", 2'b10, 15, ERR_NONE, OP_TRANSPOSE, 200'h55AA55AA);

    // Timeout with drain ending on the 2*TIMEOUT bound
    set_req(0, OP_MULTIPLY, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 200'h1234, 200'h5678);
    #1;
    chk("t4.ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    chk("t4.start_hi", eng_start, 1);
    tick();
    chk("t4.start_lo", eng_start, 0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("t4.wait_rsp", bus.rsp_valid, 0);
    end
    tick();
    chk("t4.rsp_valid", bus.rsp_valid, 2'b01);
    chk("t4.rsp_error", bus.rsp_error, ERR_TIMEOUT);
    set_req(1, OP_CONV, 4'd2, 4'd5, 4'd5, 4'd3, 4'd3, 200'hC0FFEE, 200'hBEEF);
    for (int k = 0; k < 31; k++) begin
      tick();
      chk("t4.drain_busy", busy, 1);
      chk("t4.drain_rdy", bus.req_ready, 0);
    end
    tick();
    chk("t4.drain_end_busy", busy, 0);
    chk("t4.drain_end_mode", eng_mode, MODE_IDLE);
    chk("t4.drain_end_rdy", bus.req_ready, 2'b10);

    // Timeout again; done during START is ignored, done during drain ends it
    tick();
    bus.req_valid[1] = 1'b0;
    chk("t4b.op", eng_op, OP_CONV);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t4b.w0_rsp", bus.rsp_valid, 0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("t4b.wait_rsp", bus.rsp_valid, 0);
    end
    tick();
    chk("t4b.rsp_valid", bus.rsp_valid, 2'b10);
    chk("t4b.rsp_error", bus.rsp_error, ERR_TIMEOUT);
    tick();
    tick();
    chk("t4b.drain_busy", busy, 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t4b.done_end_busy", busy, 0);
    chk("t4b.done_end_mode", eng_mode, MODE_IDLE);

    // Reset in WAIT aborts silently, then req0 has priority again
    set_req(0, OP_ADD, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 200'h42, 200'h24);
    #1;
    chk("t5.ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    chk("t5.in_wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("t5.rst_busy", busy, 0);
    chk("t5.rst_mode", eng_mode, 0);
    chk("t5.rst_start", eng_start, 0);
    chk("t5.rst_rsp", bus.rsp_valid, 0);
    chk("t5.rst_err", bus.rsp_error, 0);
    chk("t5.rst_op", eng_op, 0);
    chk("t5.rst_adata", eng_a_data, 0);
    chk("t5.rst_avalid", eng_a_valid, 0);
    rst = 1'b0;
    set_req(0, OP_CONV, 4'd5, 4'd5, 4'd5, 4'd3, 4'd3, 200'hABCDEF, 200'h1);
    set_req(1, OP_SCALAR, 4'd9, 4'd2, 4'd2, 4'd0, 4'd0, 200'h777, 200'h0);
    run_txn("t5_after", 2'b01, 1, ERR_NONE, OP_CONV, 200'hABCDEF);
    run_txn("t5_next", 2'b10, 0, ERR_INVALID_OP, OP_SCALAR, 200'h777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
